inst_seq: RTL and testbench
===========================

INST_SEQ -- requirements
Module: inst_seq

Interface
REQ-001 SHALL have parameters: row 8 (PE rows), col 8 (PE cols), len_kij 9 (kernel taps, 3x3), len_nij 36 (input pixels, 6x6), len_onij 16 (output pixels, 4x4), wd_max 64 (OFIFO watchdog cycles).
REQ-002 SHALL use a single clock and an asynchronous, active-low reset:
clk  in  1  single clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  begin one full layer sequence
abort  in  1  synchronous abort of the running sequence
ofifo_valid  in  1  core OFIFO has a full row available
inst  out  47  core instruction word
kij  out  4  current kernel tap
busy  out  1  high when the FSM is not in IDLE
done  out  1  one-cycle pulse on sequence completion
err  out  1  sticky watchdog error, cleared by start
REQ-003 inst field map SHALL be:
- [46] CEN_xmem, [45] WEN_xmem, [44:34] A_xmem
- [33] acc
- [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
- [19] CEN_wmem, [18] WEN_wmem, [17:7] A_wmem
- [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- Enables and write-enables are active low.

Function
REQ-004 inst SHALL be registered: the fields for the state in cycle N appear on inst in cycle N+1.
REQ-005 Idle word SHALL be 47'h6001_800C_0000: all CEN and WEN bits 1, all other bits 0. inst SHALL carry the idle word whenever the FSM is in IDLE, GAP or DONE.
REQ-006 FSM states SHALL be IDLE, WLOAD, WDRAIN, GAP, EXEC, FLUSH, OREAD, ACC, DONE.
REQ-007 IDLE: start=1 SHALL set kij=0, clear err and enter WLOAD. start SHALL be ignored while busy.
REQ-008 WLOAD, col cycles, t=0..col-1: CEN_wmem=0, WEN_wmem=1, A_wmem=t, ififo_wr=1, load=1; then go to WDRAIN.
REQ-009 WDRAIN, row+col-1 cycles: ififo_rd=1, load=1; then go to GAP.
REQ-010 GAP, 10 cycles: idle word; then go to EXEC.
REQ-011 EXEC, len_nij cycles, t=0..len_nij-1: CEN_xmem=0, WEN_xmem=1, A_xmem=t, l0_wr=1, l0_rd=1, execute=1; then go to FLUSH.
REQ-012 FLUSH, row+col cycles: l0_rd=1, execute=1, no memory enables; then go to OREAD.
REQ-013 OREAD behaviour:
- Each cycle with ofifo_valid=1: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=kij*len_nij+n, then n increments.
- Cycles with ofifo_valid=0: idle word.
- Exit when n==len_nij. If kij<len_kij-1: kij+1 and go to WLOAD; otherwise go to ACC, or to DONE when SEQ_ACC_EN is undefined.
REQ-014 OREAD watchdog: wd_max consecutive cycles with ofifo_valid=0 SHALL set err=1 and send the FSM to IDLE.
REQ-015 ACC processes o=0..len_onij-1 in order. Per o:
- Coordinates: oy=o/4, ox=o%4.
- j=0..len_kij-1 (ki=j/3, kj=j%3): CEN_pmem=0, WEN_pmem=1, A_pmem=j*len_nij+(oy+ki)*6+(ox+kj).
- acc=1 on cycles j=1..len_kij, i.e. one cycle lagging the reads.
- Then one idle cycle.
- 11 cycles per o; after the last o, go to DONE.
REQ-016 All address arithmetic SHALL be unsigned and zero-extended to 11 bits. The maximum address is 8*36+35=323, so no wrap is required.
REQ-017 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-018 abort=1 in any state SHALL force IDLE on the next edge with no done pulse. abort has priority over start when both are asserted together.

Reset
REQ-019 reset_n=0 SHALL asynchronously force: FSM=IDLE, inst=idle word, kij=0, busy=0, done=0, err=0, all counters 0.
REQ-020 A reset asserted mid-sequence SHALL discard all progress. After release, only a new start restarts the sequence.

Configuration
REQ-021 Macro SEQ_ACC_EN defined: the ACC state and its address generator SHALL be compiled in.
REQ-022 Macro SEQ_ACC_EN undefined: the ACC state and its address generator SHALL be absent, OREAD after the last kij SHALL go directly to DONE, and inst[33] SHALL be constant 0.

Verification
REQ-023 Reset then idle: after reset_n release -> inst==47'h6001_800C_0000, busy=0, done=0.
REQ-024 Single start with ofifo_valid tied high and SEQ_ACC_EN defined -> done pulses exactly once, after 9*(8+15+10+36+16+36)+16*11 cycles plus pipeline latency. A second start pulse while busy is ignored.
REQ-025 ACC address check: for o=5 and j=4 -> A_pmem==158 with CEN_pmem=0, WEN_pmem=1; acc goes high one cycle later.
REQ-026 Watchdog: hold ofifo_valid=0 in OREAD for 64 cycles -> err=1, busy=0, no done pulse; the next start clears err.
REQ-027 Abort during EXEC (A_xmem=20): assert abort together with start -> the next inst is the idle word, state is IDLE, the start is not taken.
REQ-028 Build without SEQ_ACC_EN: full run -> no cycle with inst[33]=1; done follows the OREAD of kij=8 with no ACC cycles between.

Source files
------------

// File: rtl/inst_seq_if.sv
// Instruction-sequencer control bundle: start/abort/ofifo_valid in, inst/status out.
// Latency: none, pure wiring between sequencer and its controller.
// Backpressure: ofifo_valid gates output reads; there is no ready path back to the core.
interface inst_seq_if;
    logic        start;
    logic        abort;
    logic        ofifo_valid;
    logic [46:0] inst;
    logic [3:0]  kij;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  start, abort, ofifo_valid,
        output inst, kij, busy, done, err
    );

    modport slave (
        output start, abort, ofifo_valid,
        input  inst, kij, busy, done, err
    );
endinterface

// File: rtl/inst_seq.sv
// Layer sequencer: emits the core instruction word for weight load, execute, OFIFO read, (ACC).
// Latency: inst is registered, so the word for the state in cycle N appears in cycle N+1.
// Backpressure: OREAD stalls on ofifo_valid=0 and a watchdog aborts with err; ACC is built only with SEQ_ACC_EN.
module inst_seq #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int len_kij  = 9,
    parameter int len_nij  = 36,
    parameter int len_onij = 16,
    parameter int wd_max   = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    inst_seq_if.master bus
);

    typedef struct packed {
        logic        cen_x;
        logic        wen_x;
        logic [10:0] a_x;
        logic        acc;
        logic        cen_p;
        logic        wen_p;
        logic [10:0] a_p;
        logic        cen_w;
        logic        wen_w;
        logic [10:0] a_w;
        logic        ofifo_rd;
        logic        ififo_wr;
        logic        ififo_rd;
        logic        l0_rd;
        logic        l0_wr;
        logic        execute;
        logic        load;
    } inst_t;

    // All memories disabled (active-low CEN/WEN high), every strobe low.
    localparam inst_t idle_word = inst_t'(47'h6001_800C_0000);

    typedef enum logic [3:0] {
        IDLE,
        WLOAD,
        WDRAIN,
        GAP,
        EXEC,
        FLUSH,
        OREAD,
`ifdef SEQ_ACC_EN
        ACC,
`endif
        DONE
    } state_t;

    localparam logic [6:0] wload_last  = 7'(col - 1);
    localparam logic [6:0] wdrain_last = 7'(row + col - 2);
    localparam logic [6:0] gap_last    = 7'd9;
    localparam logic [6:0] exec_last   = 7'(len_nij - 1);
    localparam logic [6:0] flush_last  = 7'(row + col - 1);
    localparam logic [6:0] n_last      = 7'(len_nij - 1);
    localparam logic [6:0] wd_last     = 7'(wd_max - 1);
    localparam logic [3:0] kij_last    = 4'(len_kij - 1);

    state_t      state;
    state_t      state_nxt;
    inst_t       word_q;
    inst_t       word_nxt;
    logic [6:0]  cnt;
    logic [6:0]  n_cnt;
    logic [6:0]  wd_cnt;
    logic [3:0]  kij_q;
    logic        err_q;
    logic        kij_clr;
    logic        kij_inc;
    logic        wd_trip;
    logic        err_clr;

`ifdef SEQ_ACC_EN
    // One output pixel takes len_kij reads, one trailing acc cycle and one idle cycle.
    localparam logic [3:0] acc_rd_last = 4'(len_kij - 1);
    localparam logic [3:0] acc_ph_last = 4'(len_kij + 1);
    localparam logic [3:0] o_last      = 4'(len_onij - 1);
    localparam int         in_w        = 6;

    logic [3:0]  acc_ph;
    logic [3:0]  o_cnt;
    logic [1:0]  kr;
    logic [1:0]  kc;
    logic [10:0] acc_addr;

    // psum address of tap j for output pixel (oy,ox) = (o/4, o%4) in the 6x6 input plane.
    assign acc_addr = 11'(acc_ph) * 11'(len_nij)
                    + (11'(o_cnt[3:2]) + 11'(kr)) * 11'(in_w)
                    + 11'(o_cnt[1:0]) + 11'(kc);
`endif

    // Next state and the instruction word for the current state; abort overrides everything.
    always_comb begin
        state_nxt = state;
        word_nxt  = idle_word;
        kij_clr   = 1'b0;
        kij_inc   = 1'b0;
        wd_trip   = 1'b0;
        err_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = WLOAD;
                    kij_clr   = 1'b1;
                    err_clr   = 1'b1;
                end
            end
            WLOAD: begin
                word_nxt.cen_w    = 1'b0;
                word_nxt.a_w      = 11'(cnt);
                word_nxt.ififo_wr = 1'b1;
                word_nxt.load     = 1'b1;
                if (cnt == wload_last) state_nxt = WDRAIN;
            end
            WDRAIN: begin
                word_nxt.ififo_rd = 1'b1;
                word_nxt.load     = 1'b1;
                if (cnt == wdrain_last) state_nxt = GAP;
            end
            GAP: begin
                if (cnt == gap_last) state_nxt = EXEC;
            end
            EXEC: begin
                word_nxt.cen_x   = 1'b0;
                word_nxt.a_x     = 11'(cnt);
                word_nxt.l0_wr   = 1'b1;
                word_nxt.l0_rd   = 1'b1;
                word_nxt.execute = 1'b1;
                if (cnt == exec_last) state_nxt = FLUSH;
            end
            FLUSH: begin
                word_nxt.l0_rd   = 1'b1;
                word_nxt.execute = 1'b1;
                if (cnt == flush_last) state_nxt = OREAD;
            end
            OREAD: begin
                if (bus.ofifo_valid) begin
                    word_nxt.ofifo_rd = 1'b1;
                    word_nxt.cen_p    = 1'b0;
                    word_nxt.wen_p    = 1'b0;
                    word_nxt.a_p      = 11'(kij_q) * 11'(len_nij) + 11'(n_cnt);
                    if (n_cnt == n_last) begin
                        if (kij_q < kij_last) begin
                            kij_inc   = 1'b1;
                            state_nxt = WLOAD;
                        end else begin
`ifdef SEQ_ACC_EN
                            state_nxt = ACC;
`else
                            state_nxt = DONE;
`endif
                        end
                    end
                end else if (wd_cnt == wd_last) begin
                    wd_trip   = 1'b1;
                    state_nxt = IDLE;
                end
            end
`ifdef SEQ_ACC_EN
            ACC: begin
                if (acc_ph <= acc_rd_last) begin
                    word_nxt.cen_p = 1'b0;
                    word_nxt.a_p   = acc_addr;
                end
                word_nxt.acc = (acc_ph != 4'd0) && (acc_ph <= 4'(len_kij));
                if (acc_ph == acc_ph_last && o_cnt == o_last) state_nxt = DONE;
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (bus.abort) begin
            state_nxt = IDLE;
            word_nxt  = idle_word;
            kij_clr   = 1'b0;
            kij_inc   = 1'b0;
            wd_trip   = 1'b0;
            err_clr   = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Registered instruction word, phase/read/watchdog counters, kij and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= idle_word;
            cnt    <= '0;
            n_cnt  <= '0;
            wd_cnt <= '0;
            kij_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            word_q <= word_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (state inside {WLOAD, WDRAIN, GAP, EXEC, FLUSH})
                cnt <= cnt + 7'd1;
            if (state != OREAD || state_nxt != OREAD)
                n_cnt <= '0;
            else if (bus.ofifo_valid)
                n_cnt <= n_cnt + 7'd1;
            if (state != OREAD || state_nxt != OREAD || bus.ofifo_valid)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 7'd1;
            if (kij_clr)      kij_q <= '0;
            else if (kij_inc) kij_q <= kij_q + 4'd1;
            if (wd_trip)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
        end
    end

`ifdef SEQ_ACC_EN
    // ACC walker: phase within a pixel, kernel row/col of the current tap, pixel index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_ph <= '0;
            o_cnt  <= '0;
            kr     <= '0;
            kc     <= '0;
        end else if (state != ACC || state_nxt != ACC) begin
            acc_ph <= '0;
            o_cnt  <= '0;
            kr     <= '0;
            kc     <= '0;
        end else if (acc_ph == acc_ph_last) begin
            acc_ph <= '0;
            kr     <= '0;
            kc     <= '0;
            o_cnt  <= o_cnt + 4'd1;
        end else begin
            acc_ph <= acc_ph + 4'd1;
            if (kc == 2'd2) begin
                kc <= '0;
                kr <= kr + 2'd1;
            end else begin
                kc <= kc + 2'd1;
            end
        end
    end
`endif

    assign bus.inst = word_q;
    assign bus.kij  = kij_q;
    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.err  = err_q;

endmodule

// File: tb/tb_inst_seq.sv
// Bench for inst_seq: cycle-exact expected instruction stream from a loop-level model.
// Latency: each expected word is checked one edge after the cycle that produces it.
// Backpressure: ofifo_valid is randomized in OREAD; a stall run exercises the watchdog.
module tb_inst_seq;
    localparam int ROW   = 8;
    localparam int COL   = 8;
    localparam int LKIJ  = 9;
    localparam int LNIJ  = 36;
    localparam int LONIJ = 16;
    localparam int WD    = 64;
    localparam logic [46:0] IDLE_W = 47'h6001_800C_0000;

    localparam int M_HIGH  = 0;
    localparam int M_RAND  = 1;
    localparam int M_WD    = 2;
    localparam int M_ABORT = 3;

`ifdef SEQ_ACC_EN
    localparam int EXP_DONE_EDGE = LKIJ * (COL + ROW + COL - 1 + 10 + LNIJ + ROW + COL + LNIJ) + LONIJ * 11;
    localparam int EXP_ACC_HI    = LONIJ * LKIJ;
`else
    localparam int EXP_DONE_EDGE = LKIJ * (COL + ROW + COL - 1 + 10 + LNIJ + ROW + COL + LNIJ);
    localparam int EXP_ACC_HI    = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    inst_seq_if bus_if ();

    inst_seq #(
        .row(ROW), .col(COL), .len_kij(LKIJ), .len_nij(LNIJ), .len_onij(LONIJ), .wd_max(WD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus_if)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int done_cnt = 0;
    int done_edge = -1;
    int acc_hi = 0;
    bit noise_en = 1'b0;

    task automatic chk(input string tag, input logic [46:0] obs, input logic [46:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: inputs were set by the caller; compare the word this cycle produced.
    task automatic cyc(input logic [46:0] expw, input string tag);
        @(posedge clk);
        #1;
        edge_cnt++;
        if (bus_if.done) begin
            done_cnt++;
            done_edge = edge_cnt;
        end
        if (bus_if.inst[33]) acc_hi++;
        chk(tag, bus_if.inst, expw);
        if (noise_en) bus_if.ofifo_valid = 1'($urandom);
    endtask

    function automatic logic [46:0] w_wload(input int t);
        logic [46:0] w;
        w = IDLE_W; w[19] = 1'b0; w[17:7] = 11'(t); w[5] = 1'b1; w[0] = 1'b1;
        return w;
    endfunction

    function automatic logic [46:0] w_wdrain();
        logic [46:0] w;
        w = IDLE_W; w[4] = 1'b1; w[0] = 1'b1;
        return w;
    endfunction

    function automatic logic [46:0] w_exec(input int t);
        logic [46:0] w;
        w = IDLE_W; w[46] = 1'b0; w[44:34] = 11'(t); w[3] = 1'b1; w[2] = 1'b1; w[1] = 1'b1;
        return w;
    endfunction

    function automatic logic [46:0] w_flush();
        logic [46:0] w;
        w = IDLE_W; w[3] = 1'b1; w[1] = 1'b1;
        return w;
    endfunction

    function automatic logic [46:0] w_oread(input int a);
        logic [46:0] w;
        w = IDLE_W; w[6] = 1'b1; w[32] = 1'b0; w[31] = 1'b0; w[30:20] = 11'(a);
        return w;
    endfunction

    function automatic logic [46:0] w_acc(input bit rd, input int a, input bit accb);
        logic [46:0] w;
        w = IDLE_W;
        if (rd) begin w[32] = 1'b0; w[30:20] = 11'(a); end
        w[33] = accb;
        return w;
    endfunction

    // Whole-layer model: walks kij, phases and pixels in spec order and checks every word.
    task automatic run_seq(input int mode);
        int n;
        int streak;
        logic v;
        noise_en = (mode == M_RAND);
        bus_if.ofifo_valid = 1'b1;
        edge_cnt = -1;
        done_cnt = 0;
        done_edge = -1;
        acc_hi = 0;
        bus_if.start = 1'b1;
        cyc(IDLE_W, "start_idle");
        bus_if.start = 1'b0;
        chk("busy_after_start", 47'(bus_if.busy), 47'd1);
        chk("err_after_start", 47'(bus_if.err), 47'd0);
        for (int k = 0; k < LKIJ; k++) begin
            chk("kij_value", 47'(bus_if.kij), 47'(k));
            for (int t = 0; t < COL; t++) cyc(w_wload(t), "wload");
            for (int t = 0; t < ROW + COL - 1; t++) cyc(w_wdrain(), "wdrain");
            for (int t = 0; t < 10; t++) cyc(IDLE_W, "gap");
            for (int t = 0; t < LNIJ; t++) begin
                if (mode == M_ABORT && t == 20) begin
                    bus_if.abort = 1'b1;
                    bus_if.start = 1'b1;
                    cyc(IDLE_W, "abort_word");
                    bus_if.abort = 1'b0;
                    bus_if.start = 1'b0;
                    chk("abort_busy", 47'(bus_if.busy), 47'd0);
                    cyc(IDLE_W, "abort_after");
                    chk("abort_start_ignored", 47'(bus_if.busy), 47'd0);
                    chk("abort_no_done", 47'(done_cnt), 47'd0);
                    return;
                end
                if (mode == M_HIGH && k == 0 && t == 5) bus_if.start = 1'b1;
                cyc(w_exec(t), "exec");
                bus_if.start = 1'b0;
            end
            for (int t = 0; t < ROW + COL; t++) cyc(w_flush(), "flush");
            if (mode == M_WD) begin
                bus_if.ofifo_valid = 1'b0;
                for (int i = 0; i < WD; i++) begin
                    cyc(IDLE_W, "wd_idle");
                    if (i == WD - 2) begin
                        chk("wd_busy_before_trip", 47'(bus_if.busy), 47'd1);
                        chk("wd_err_before_trip", 47'(bus_if.err), 47'd0);
                    end
                end
                chk("wd_err", 47'(bus_if.err), 47'd1);
                chk("wd_busy", 47'(bus_if.busy), 47'd0);
                cyc(IDLE_W, "wd_after");
                chk("wd_no_done", 47'(done_cnt), 47'd0);
                chk("wd_err_sticky", 47'(bus_if.err), 47'd1);
                return;
            end
            n = 0;
            streak = 0;
            while (n < LNIJ) begin
                v = (mode == M_RAND) ? (($urandom_range(0, 3) != 0) || (streak >= 8)) : 1'b1;
                bus_if.ofifo_valid = v;
                if (v) begin
                    cyc(w_oread(k * LNIJ + n), "oread");
                    n++;
                    streak = 0;
                end else begin
                    cyc(IDLE_W, "oread_wait");
                    streak++;
                end
            end
        end
`ifdef SEQ_ACC_EN
        for (int o = 0; o < LONIJ; o++) begin
            for (int p = 0; p <= LKIJ + 1; p++) begin
                int a;
                a = p * LNIJ + (o / 4 + p / 3) * 6 + (o % 4 + p % 3);
                cyc(w_acc(p < LKIJ, a, (p >= 1) && (p <= LKIJ)), "acc");
                if (o == 5 && p == 4) begin
                    chk("acc_o5_j4_addr", 47'(bus_if.inst[30:20]), 47'd158);
                    chk("acc_o5_j4_cen_wen", 47'(bus_if.inst[32:31]), 47'd1);
                end
                if (o == 5 && p == 5) chk("acc_o5_j4_lag", 47'(bus_if.inst[33]), 47'd1);
            end
        end
`endif
        chk("done_pulse", 47'(bus_if.done), 47'd1);
        cyc(IDLE_W, "done_word");
        chk("done_one_cycle", 47'(bus_if.done), 47'd0);
        chk("busy_after_done", 47'(bus_if.busy), 47'd0);
        chk("done_count", 47'(done_cnt), 47'd1);
        chk("acc_cycles", 47'(acc_hi), 47'(EXP_ACC_HI));
        if (mode == M_HIGH) chk("done_latency", 47'(done_edge), 47'(EXP_DONE_EDGE));
    endtask

    initial begin
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        bus_if.ofifo_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_inst", bus_if.inst, IDLE_W);
        chk("reset_busy", 47'(bus_if.busy), 47'd0);
        chk("reset_done", 47'(bus_if.done), 47'd0);
        chk("reset_err", 47'(bus_if.err), 47'd0);
        chk("reset_kij", 47'(bus_if.kij), 47'd0);
        reset_n = 1'b1;
        cyc(IDLE_W, "post_reset_inst");
        chk("post_reset_busy", 47'(bus_if.busy), 47'd0);
        chk("post_reset_done", 47'(bus_if.done), 47'd0);

        run_seq(M_HIGH);
        run_seq(M_RAND);

        run_seq(M_WD);
        noise_en = 1'b0;
        bus_if.start = 1'b1;
        cyc(IDLE_W, "restart_idle");
        bus_if.start = 1'b0;
        chk("restart_clears_err", 47'(bus_if.err), 47'd0);
        chk("restart_busy", 47'(bus_if.busy), 47'd1);
        bus_if.abort = 1'b1;
        cyc(IDLE_W, "abort_in_wload");
        bus_if.abort = 1'b0;
        chk("abort_wload_busy", 47'(bus_if.busy), 47'd0);

        run_seq(M_ABORT);
        noise_en = 1'b0;

        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (200) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_inst", bus_if.inst, IDLE_W);
        chk("midreset_busy", 47'(bus_if.busy), 47'd0);
        chk("midreset_kij", 47'(bus_if.kij), 47'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(IDLE_W, "after_midreset_inst");
            chk("after_midreset_busy", 47'(bus_if.busy), 47'd0);
        end

        run_seq(M_RAND);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
